ex_muldiv_unit: RTL and testbench
=================================

// Module: ex_muldiv_unit
// PURPOSE
//  Iterative multiply/divide unit in EX, fed by the ID/EX pipeline register outputs (RS/RT data, RD addr).
//  Runs one 32-cycle shift-add or restoring-divide sequence per op.
//  Holds the front of the pipeline through stall_o; ID/EX stall_i and upstream stages obey it.
//  Returns result, rd_addr and regwrite for the EX/MEM register on a one-cycle done_o pulse.
// PARAMETERS
//  WIDTH   32   operand/result width; iteration count = WIDTH
//  CNT_W   6    iteration counter width; must hold WIDTH
// PORTS
//  clk_i        in   1      clock; all state updates on posedge
//  rst_n_i      in   1      synchronous reset, active-low
//  start_i      in   1      valid muldiv op presented by ID/EX this cycle
//  op_i         in   2      00 MUL (signed, low word), 01 DIV (signed quot), 10 REM (signed rem), 11 DIVU (unsigned quot)
//  rs_i         in   WIDTH  operand A / dividend (ID/EX RS_o)
//  rt_i         in   WIDTH  operand B / divisor (ID/EX RT_o)
//  rd_addr_i    in   5      destination register
//  kill_i       in   1      abort in-flight op (branch flush / exception)
//  stall_o      out  1      freeze ID/EX and upstream stages
//  busy_o       out  1      state != IDLE
//  done_o       out  1      result valid, exactly one cycle
//  result_o     out  WIDTH  result; stable while done_o=1, holds last value otherwise
//  rd_addr_o    out  5      destination of completed op
//  regwrite_o   out  1      equals done_o; write-enable toward EX/MEM
// BEHAVIOUR
//  Reset (rst_n_i=0 at posedge):
//   state=IDLE, counter=0. stall_o, busy_o, done_o, regwrite_o = 0. result_o=0, rd_addr_o=0.
//   Overrides all other inputs, including mid-operation; the in-flight op is dropped silently.
//  FSM: IDLE -> CALC -> DONE -> IDLE.
//   IDLE: start_i=1 & kill_i=0 at edge N -> CALC.
//    Latches op, rd_addr, operand magnitudes and result sign; clears counter.
//   CALC: one bit per edge, counter++. After WIDTH edges (edge N+WIDTH) -> DONE; sign fix applied on that transition.
//   DONE: done_o=regwrite_o=1 for that single cycle; next edge (N+WIDTH+1) -> IDLE.
//   Latency: start edge to done cycle = WIDTH+1 edges (33 at default); fixed, no data-dependent early exit.
//  stall_o = (IDLE & start_i & ~kill_i) | CALC. This is combinational, so the ID/EX register holds from the start cycle.
//   stall_o is low in DONE so the pipeline advances and EX/MEM captures the result.
//  start_i while busy (CALC/DONE): ignored; no queueing.
//  kill_i=1: any state -> IDLE at next edge, with no done_o.
//   kill_i and start_i together in IDLE: kill wins, op not accepted.
//   kill_i in DONE: done_o still seen this cycle; state -> IDLE.
//  Arithmetic:
//   MUL: low WIDTH bits of the two's-complement product. Upper half is discarded; overflow wraps.
//   DIV/REM signed: operate on magnitudes. Quotient sign = sign(rs) XOR sign(rt); remainder takes sign(rs).
//   DIVU: unsigned restoring division; quotient only.
//   Divide by zero: DIV/DIVU -> all ones; REM -> rs_i. Still takes full latency.
//   Overflow (-2^(WIDTH-1) / -1): DIV -> 32'h8000_0000, REM -> 0.
//  result_o/rd_addr_o update only on the CALC->DONE edge and hold afterwards.
// TESTING
//  T1 reset: rst_n_i=0 during CALC -> next cycle IDLE, all outputs 0, no done_o ever for that op.
//  T2 MUL rs=-7 rt=6 start@N -> stall_o high edges N..N+31; done_o in cycle after edge N+32; result=32'hFFFF_FFD6.
//  T3 DIV rs=-100 rt=7 -> quotient 32'hFFFF_FFF2 (-14). REM same operands -> 32'hFFFF_FFFE (-2). DIVU 100/7 -> 14.
//  T4 div-by-zero and overflow:
//     DIVU 5/0 -> 32'hFFFF_FFFF; REM 5/0 -> 5.
//     DIV 32'h8000_0000 / 32'hFFFF_FFFF -> 32'h8000_0000; REM same operands -> 0.
//  T5 kill_i at CALC count 10 -> IDLE next edge, no done_o, stall_o low.
//     start_i with kill_i in IDLE -> not accepted.
//  T6 start_i held high across an op -> exactly one done_o.
//     Second op accepted only once back in IDLE; each rd_addr_o matches its own op.

Source files
------------

// File: rtl/ex_muldiv_unit.sv
// Iterative EX-stage multiply/divide unit: one result bit per cycle over WIDTH cycles,
// freezing the front of the pipeline via stall_o and handing the result to EX/MEM on done_o.
module ex_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] rs_i,
    input  logic [WIDTH-1:0] rt_i,
    input  logic [4:0]       rd_addr_i,
    input  logic             kill_i,
    output logic             stall_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic [4:0]       rd_addr_o,
    output logic             regwrite_o
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic [4:0]       rd_q, rd_d;
    // a: multiplicand (MUL) or dividend/quotient shift register (DIV*)
    // b: multiplier (MUL) or divisor magnitude (DIV*)
    // acc: product accumulator (MUL) or partial remainder (DIV*)
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
    logic             neg_q, neg_d, dz_q, dz_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [4:0]       rd_addr_q, rd_addr_d;

    logic             rs_neg, rt_neg, ge;
    logic [WIDTH:0]   rem_shift, rem_sub;

    always_comb begin
        rs_neg    = (op_i == OP_DIV || op_i == OP_REM) && rs_i[WIDTH-1];
        rt_neg    = (op_i == OP_DIV || op_i == OP_REM) && rt_i[WIDTH-1];
        rem_shift = {acc_q, a_q[WIDTH-1]};
        rem_sub   = rem_shift - {1'b0, b_q};
        ge        = (rem_shift >= {1'b0, b_q});
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        rd_d      = rd_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        neg_d     = neg_q;
        dz_d      = dz_q;
        result_d  = result_q;
        rd_addr_d = rd_addr_q;

        case (state_q)
            S_IDLE: begin
                if (start_i && !kill_i) begin
                    state_d = S_CALC;
                    cnt_d   = '0;
                    op_d    = op_i;
                    rd_d    = rd_addr_i;
                    acc_d   = '0;
                    dz_d    = (rt_i == '0);
                    // Low word of a two's-complement product needs no sign handling.
                    if (op_i == OP_MUL) begin
                        a_d   = rs_i;
                        b_d   = rt_i;
                        neg_d = 1'b0;
                    end else begin
                        a_d   = rs_neg ? -rs_i : rs_i;
                        b_d   = rt_neg ? -rt_i : rt_i;
                        neg_d = (op_i == OP_REM) ? rs_neg : (rs_neg ^ rt_neg);
                    end
                end
            end
            S_CALC: begin
                cnt_d = cnt_q + 1'b1;
                if (op_q == OP_MUL) begin
                    acc_d = acc_q + (b_q[0] ? a_q : '0);
                    a_d   = a_q << 1;
                    b_d   = b_q >> 1;
                end else begin
                    a_d   = {a_q[WIDTH-2:0], ge};
                    acc_d = ge ? rem_sub[WIDTH-1:0] : rem_shift[WIDTH-1:0];
                end
                if (cnt_q == CNT_LAST) begin
                    state_d   = S_DONE;
                    rd_addr_d = rd_q;
                    if (op_q == OP_MUL)
                        result_d = acc_d;
                    else if (op_q == OP_REM)
                        result_d = neg_q ? -acc_d : acc_d;
                    else if (dz_q)
                        result_d = '1;
                    else
                        result_d = neg_q ? -a_d : a_d;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (kill_i) begin
            state_d   = S_IDLE;
            result_d  = result_q;
            rd_addr_d = rd_addr_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            rd_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            neg_q     <= 1'b0;
            dz_q      <= 1'b0;
            result_q  <= '0;
            rd_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            rd_q      <= rd_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            neg_q     <= neg_d;
            dz_q      <= dz_d;
            result_q  <= result_d;
            rd_addr_q <= rd_addr_d;
        end
    end

    assign stall_o    = (state_q == S_IDLE && start_i && !kill_i) || (state_q == S_CALC);
    assign busy_o     = (state_q != S_IDLE);
    assign done_o     = (state_q == S_DONE);
    assign regwrite_o = done_o;
    assign result_o   = result_q;
    assign rd_addr_o  = rd_addr_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: latency, arithmetic corner cases, kill, reset and start hold.
module tb_ex_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs, rt;
    logic [4:0]  rd_addr;
    logic        kill;
    logic        stall, busy, done, regwrite;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int checks = 0;
    int errors = 0;

    ex_muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .op_i(op),
        .rs_i(rs), .rt_i(rt), .rd_addr_i(rd_addr), .kill_i(kill),
        .stall_o(stall), .busy_o(busy), .done_o(done),
        .result_o(result), .rd_addr_o(rd_out), .regwrite_o(regwrite)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Launch one op, follow it to done_o and check latency, stall, result and destination.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp);
        int  cyc;
        logic stall_ok;
        @(negedge clk);
        start = 1'b1; op = o; rs = a; rt = b; rd_addr = rd;
        #1 check({tag, "_stall_start"}, {31'd0, stall}, 32'd1);
        @(posedge clk); #1;
        start = 1'b0; rs = 32'h0; rt = 32'h0; rd_addr = 5'd0;
        cyc = 0; stall_ok = 1'b1;
        do begin
            @(negedge clk);
            cyc++;
            if (!done && !stall) stall_ok = 1'b0;
        end while (!done && cyc < 100);
        check({tag, "_latency"},  cyc, 33);
        check({tag, "_stall_calc"}, {31'd0, stall_ok}, 32'd1);
        check({tag, "_result"},   result, exp);
        check({tag, "_rd"},       {27'd0, rd_out}, {27'd0, rd});
        check({tag, "_regwrite"}, {31'd0, regwrite}, 32'd1);
        check({tag, "_stall_done"}, {31'd0, stall}, 32'd0);
        @(negedge clk);
        check({tag, "_done_pulse"}, {30'd0, done, busy}, 32'd0);
        check({tag, "_hold"}, result, exp);
    endtask

    task automatic expect_no_done(input string tag, input int ncyc);
        int seen = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (done) seen++;
        end
        check(tag, seen, 0);
    endtask

    initial begin
        int cyc, dones;
        rst_n = 1'b0; start = 1'b0; op = 2'b00; rs = '0; rt = '0; rd_addr = '0; kill = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_outputs", {26'd0, stall, busy, done, regwrite, 2'b00}, 32'd0);
        check("rst_result", result, 32'h0);
        check("rst_rd", {27'd0, rd_out}, 32'd0);
        rst_n = 1'b1;

        // Multiply
        run_op("mul_neg", 2'b00, 32'hFFFF_FFF9, 32'd6, 5'd3, 32'hFFFF_FFD6);
        run_op("mul_wrap", 2'b00, 32'h0001_0000, 32'h0001_0000, 5'd4, 32'h0);
        run_op("mul_negneg", 2'b00, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 5'd5, 32'd15);

        // Reset in the middle of an op drops it silently
        @(negedge clk);
        start = 1'b1; op = 2'b11; rs = 32'd100; rt = 32'd7; rd_addr = 5'd12;
        @(negedge clk); start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_ctrl", {28'd0, stall, busy, done, regwrite}, 32'd0);
        check("rst_mid_result", result, 32'h0);
        check("rst_mid_rd", {27'd0, rd_out}, 32'd0);
        rst_n = 1'b1;
        expect_no_done("rst_mid_nodone", 40);

        // Divide / remainder
        run_op("div_neg", 2'b01, 32'hFFFF_FF9C, 32'd7, 5'd6, 32'hFFFF_FFF2);
        run_op("rem_neg", 2'b10, 32'hFFFF_FF9C, 32'd7, 5'd7, 32'hFFFF_FFFE);
        run_op("divu", 2'b11, 32'd100, 32'd7, 5'd8, 32'd14);
        run_op("divu_big", 2'b11, 32'hFFFF_FFFF, 32'd2, 5'd9, 32'h7FFF_FFFF);

        // Divide by zero and overflow
        run_op("divu_zero", 2'b11, 32'd5, 32'd0, 5'd10, 32'hFFFF_FFFF);
        run_op("rem_zero", 2'b10, 32'd5, 32'd0, 5'd11, 32'd5);
        run_op("rem_zero_neg", 2'b10, 32'hFFFF_FFFB, 32'd0, 5'd13, 32'hFFFF_FFFB);
        run_op("div_zero_neg", 2'b01, 32'hFFFF_FFF9, 32'd0, 5'd14, 32'hFFFF_FFFF);
        run_op("div_ovf", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000);
        run_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h0);

        // Kill at CALC count 10
        @(negedge clk);
        start = 1'b1; op = 2'b00; rs = 32'd9; rt = 32'd9; rd_addr = 5'd20;
        @(negedge clk); start = 1'b0;
        repeat (10) @(negedge clk);
        kill = 1'b1;
        @(negedge clk); kill = 1'b0;
        check("kill_idle", {30'd0, busy, stall}, 32'd0);
        expect_no_done("kill_nodone", 40);
        check("kill_result_held", result, 32'h0);

        // Start together with kill in IDLE is refused
        @(negedge clk);
        start = 1'b1; kill = 1'b1; op = 2'b11; rs = 32'd50; rt = 32'd5; rd_addr = 5'd21;
        #1 check("startkill_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        start = 1'b0; kill = 1'b0;
        check("startkill_busy", {31'd0, busy}, 32'd0);
        expect_no_done("startkill_nodone", 40);

        // Start held across an op: one done, destination latched at acceptance
        @(negedge clk);
        start = 1'b1; op = 2'b11; rs = 32'd100; rt = 32'd7; rd_addr = 5'd9;
        @(negedge clk);
        rd_addr = 5'd30; op = 2'b00; rs = 32'd1; rt = 32'd1;
        cyc = 1;
        while (!done && cyc < 100) begin @(negedge clk); cyc++; end
        check("hold_latency", cyc, 33);
        check("hold_result", result, 32'd14);
        check("hold_rd", {27'd0, rd_out}, 32'd9);
        start = 1'b0;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("hold_single_done", dones, 0);
        run_op("second_op", 2'b00, 32'd3, 32'd5, 5'd17, 32'd15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
